// File: rtl/seq_det_n_pkg.sv
// seq_det_n shared constants and types.
// Default pattern geometry shared by RTL and bench.
package seq_det_n_pkg;

  localparam int SEQ_N = 5;
  localparam logic [SEQ_N-1:0] SEQ_PATTERN = 5'b10110;

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_RUN  = 1'b1
  } seq_state_e;

endpackage

// File: rtl/seq_det_n_sat_cnt.sv
// sat_cnt: saturating up-counter with sync clear.
// Clear wins over increment; holds at all-ones.
module sat_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  localparam logic [W-1:0] MAX = '1;

  logic [W-1:0] r_q;

  // count up on inc, stop at MAX, clr to zero
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_q <= '0;
    end else if (clr) begin
      r_q <= '0;
    end else if (inc && (r_q != MAX)) begin
      r_q <= r_q + W'(1);
    end
  end

  assign q = r_q;

endmodule

// File: rtl/seq_det_n.sv
// seq_det_n: serial pattern detector, loadable pattern.
// Overlap select, clock enable, saturating hit count.
module seq_det_n
  import seq_det_n_pkg::*;
#(
  parameter int             N       = SEQ_N,
  parameter logic [N-1:0]   PATTERN = SEQ_PATTERN,
  parameter bit             OVERLAP = 1'b1,
  parameter int             CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             x,
  input  logic             clr,
  input  logic [N-1:0]     pat_in,
  input  logic             pat_we,
  output logic             o,
  output logic [CNT_W-1:0] hits
);

  localparam int FW = $clog2(N + 1);
  localparam logic [FW-1:0] FULL = FW'(N);

  seq_state_e   r_state;
  seq_state_e   w_state_nxt;
  logic [N-1:0] r_hist;
  logic [N-1:0] r_pat;
  logic [FW-1:0] r_fill;
  logic         r_o;

  logic [N-1:0]  w_hist_sh;
  logic [FW-1:0] w_fill_sh;
  logic          w_sample;
  logic          w_match;
  logic [N-1:0]  w_hist_nxt;
  logic [N-1:0]  w_pat_nxt;
  logic [FW-1:0] w_fill_nxt;
  logic          w_o_nxt;

  // post-shift view of history and fill for this edge
  always_comb begin
    w_sample  = en & ~clr & ~pat_we;
    w_hist_sh = {r_hist[N-2:0], x};
    w_fill_sh = (r_state == ST_FILL) ? r_fill + FW'(1) : r_fill;
    w_match   = w_sample &&
                (w_fill_sh == FULL) &&
                (w_hist_sh == r_pat);
  end

  // next-state: clr/pat_we restart, else shift on en
  always_comb begin
    w_hist_nxt = r_hist;
    w_pat_nxt  = r_pat;
    w_fill_nxt = r_fill;
    w_o_nxt    = 1'b0;
    if (clr) begin
      w_fill_nxt = '0;
    end
    if (pat_we) begin
      w_pat_nxt  = pat_in;
      w_fill_nxt = '0;
    end
    if (w_sample) begin
      w_hist_nxt = w_hist_sh;
      w_fill_nxt = w_fill_sh;
      if (w_match) begin
        w_o_nxt = 1'b1;
        if (!OVERLAP) begin
          w_fill_nxt = '0;
        end
      end
    end
    w_state_nxt = (w_fill_nxt == FULL) ? ST_RUN : ST_FILL;
  end

  // history, fill, pattern, detect pulse and FSM state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_FILL;
      r_hist  <= '0;
      r_pat   <= PATTERN;
      r_fill  <= '0;
      r_o     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_hist  <= w_hist_nxt;
      r_pat   <= w_pat_nxt;
      r_fill  <= w_fill_nxt;
      r_o     <= w_o_nxt;
    end
  end

  sat_cnt #(
    .W (CNT_W)
  ) u_hits (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .inc (w_match),
    .q   (hits)
  );

  assign o = r_o;

endmodule

// File: tb/tb_seq_det_n.sv
// tb_seq_det_n: directed bench for seq_det_n.
// Three instances: overlap, non-overlap, 2-bit counter.
module tb_seq_det_n;

  logic       clk;
  logic       rst;
  logic       en;
  logic       x;
  logic       clr;
  logic [4:0] pat_in;
  logic       pat_we;

  logic       o_a;
  logic       o_b;
  logic       o_c;
  logic [7:0] hits_a;
  logic [7:0] hits_b;
  logic [1:0] hits_c;

  int nvec;
  int nerr;

  seq_det_n #(
    .N (5), .PATTERN (5'b10110), .OVERLAP (1'b1), .CNT_W (8)
  ) dut_a (
    .clk (clk), .rst (rst), .en (en), .x (x), .clr (clr),
    .pat_in (pat_in), .pat_we (pat_we), .o (o_a), .hits (hits_a)
  );

  seq_det_n #(
    .N (5), .PATTERN (5'b10110), .OVERLAP (1'b0), .CNT_W (8)
  ) dut_b (
    .clk (clk), .rst (rst), .en (en), .x (x), .clr (clr),
    .pat_in (pat_in), .pat_we (pat_we), .o (o_b), .hits (hits_b)
  );

  seq_det_n #(
    .N (5), .PATTERN (5'b10110), .OVERLAP (1'b1), .CNT_W (2)
  ) dut_c (
    .clk (clk), .rst (rst), .en (en), .x (x), .clr (clr),
    .pat_in (pat_in), .pat_we (pat_we), .o (o_c), .hits (hits_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sbit(input logic b, input logic e);
    en = e;
    x  = b;
    tick();
    en = 1'b0;
  endtask

  initial begin
    logic [7:0] s8;
    logic [7:0] ea;
    logic [7:0] eb;
    nvec   = 0;
    nerr   = 0;
    rst    = 1'b0;
    en     = 1'b0;
    x      = 1'b0;
    clr    = 1'b0;
    pat_in = 5'b0;
    pat_we = 1'b0;

    // reset state
    #2;
    chk("rst_o_a", 32'(o_a), 32'd0);
    chk("rst_hits_a", 32'(hits_a), 32'd0);
    chk("rst_hits_c", 32'(hits_c), 32'd0);
    #10 rst = 1'b1;
    tick();

    // 1,0,1,1,0,1,1,0 on default pattern
    s8 = 8'b10110110;
    ea = 8'b00001001;
    eb = 8'b00001000;
    for (int i = 0; i < 8; i++) begin
      sbit(s8[7-i], 1'b1);
      chk($sformatf("ovl_o_a_b%0d", i + 1), 32'(o_a), 32'(ea[7-i]));
      chk($sformatf("ovl_o_b_b%0d", i + 1), 32'(o_b), 32'(eb[7-i]));
    end
    chk("ovl_hits_a", 32'(hits_a), 32'd2);
    chk("ovl_hits_b", 32'(hits_b), 32'd1);
    chk("ovl_hits_c", 32'(hits_c), 32'd2);

    // clr
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_hits_a", 32'(hits_a), 32'd0);
    chk("clr_hits_b", 32'(hits_b), 32'd0);
    chk("clr_o_a", 32'(o_a), 32'd0);

    // en gap between bit 2 and bit 3
    sbit(1'b1, 1'b1);
    sbit(1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      sbit(1'b1, 1'b0);
      chk($sformatf("gap_o_a_%0d", i), 32'(o_a), 32'd0);
    end
    sbit(1'b1, 1'b1);
    sbit(1'b1, 1'b1);
    chk("gap_o_a_b4", 32'(o_a), 32'd0);
    sbit(1'b0, 1'b1);
    chk("gap_o_a_b5", 32'(o_a), 32'd1);
    chk("gap_o_b_b5", 32'(o_b), 32'd1);
    chk("gap_hits_a", 32'(hits_a), 32'd1);
    sbit(1'b0, 1'b0);
    chk("gap_o_a_after", 32'(o_a), 32'd0);

    // pat_we mid partial 1,1,0
    sbit(1'b1, 1'b1);
    sbit(1'b1, 1'b1);
    pat_in = 5'b11001;
    pat_we = 1'b1;
    sbit(1'b0, 1'b1);
    pat_we = 1'b0;
    chk("pwe_o_a", 32'(o_a), 32'd0);
    s8 = 8'b11001000;
    ea = 8'b00001000;
    for (int i = 0; i < 5; i++) begin
      sbit(s8[7-i], 1'b1);
      chk($sformatf("pwe_o_a_b%0d", i + 1), 32'(o_a), 32'(ea[7-i]));
    end
    chk("pwe_o_b", 32'(o_b), 32'd1);
    chk("pwe_hits_a", 32'(hits_a), 32'd2);
    chk("pwe_hits_b", 32'(hits_b), 32'd2);
    chk("pwe_hits_c", 32'(hits_c), 32'd2);

    // clr + pat_we together, then 10 ones
    pat_in = 5'b11111;
    pat_we = 1'b1;
    clr    = 1'b1;
    tick();
    pat_we = 1'b0;
    clr    = 1'b0;
    chk("cpw_hits_a", 32'(hits_a), 32'd0);
    chk("cpw_hits_c", 32'(hits_c), 32'd0);
    for (int i = 1; i <= 10; i++) begin
      sbit(1'b1, 1'b1);
      chk($sformatf("sat_o_c_b%0d", i), 32'(o_c), (i >= 5) ? 32'd1 : 32'd0);
      chk($sformatf("sat_hits_c_b%0d", i), 32'(hits_c),
          (i >= 7) ? 32'd3 : ((i >= 5) ? 32'(i - 4) : 32'd0));
      chk($sformatf("sat_o_b_b%0d", i), 32'(o_b),
          ((i == 5) || (i == 10)) ? 32'd1 : 32'd0);
    end
    chk("sat_hits_a", 32'(hits_a), 32'd6);
    chk("sat_hits_b", 32'(hits_b), 32'd2);

    // clr, then five fresh ones needed
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("sclr_hits_c", 32'(hits_c), 32'd0);
    for (int i = 1; i <= 5; i++) begin
      sbit(1'b1, 1'b1);
      chk($sformatf("sclr_o_c_b%0d", i), 32'(o_c), (i == 5) ? 32'd1 : 32'd0);
    end
    chk("sclr_hits_c_end", 32'(hits_c), 32'd1);
    chk("sclr_hits_a_end", 32'(hits_a), 32'd1);

    // async reset mid-match on 10110
    pat_in = 5'b10110;
    pat_we = 1'b1;
    tick();
    pat_we = 1'b0;
    sbit(1'b1, 1'b1);
    sbit(1'b0, 1'b1);
    sbit(1'b1, 1'b1);
    sbit(1'b1, 1'b1);
    #2 rst = 1'b0;
    #1;
    chk("arst_o_a", 32'(o_a), 32'd0);
    chk("arst_hits_a", 32'(hits_a), 32'd0);
    chk("arst_hits_c", 32'(hits_c), 32'd0);
    #4 rst = 1'b1;
    sbit(1'b0, 1'b1);
    chk("arst_b5_o_a", 32'(o_a), 32'd0);
    chk("arst_b5_hits_a", 32'(hits_a), 32'd0);

    // reset restored PATTERN: a fresh 10110 detects
    s8 = 8'b10110000;
    for (int i = 0; i < 5; i++) begin
      sbit(s8[7-i], 1'b1);
    end
    chk("post_o_a", 32'(o_a), 32'd1);
    chk("post_hits_a", 32'(hits_a), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
